// File: rtl/avalon_pwm_pkg.sv
// Shared definitions for the multi-channel Avalon PWM: register map,
// ID word and channel configuration type.
// Optional feature macro: AVALON_PWM_IRQ_EN (adds IRQ_MASK at word 7 and
// moves the channel register block to word 8).
package avalon_pwm_pkg;

    localparam int REG_CTRL     = 0;
    localparam int REG_PRESCALE = 1;
    localparam int REG_STATUS   = 2;
    localparam int REG_ID       = 3;
    localparam int REG_IRQ_MASK = 7;

`ifdef AVALON_PWM_IRQ_EN
    localparam int CH_BASE = 8;
`else
    localparam int CH_BASE = 4;
`endif

    // Each channel occupies three consecutive words: CFG, PERIOD, DUTY.
    localparam int CH_STRIDE  = 3;
    localparam int OFS_CFG    = 0;
    localparam int OFS_PERIOD = 1;
    localparam int OFS_DUTY   = 2;

    localparam logic [7:0] ID_MAGIC   = 8'h50;
    localparam logic [7:0] ID_VERSION = 8'h02;

    // Packed so that bit0 = EN and bit1 = INV, matching the CFG register.
    typedef struct packed {
        logic inv;
        logic en;
    } pwm_cfg_t;

    // ID word: magic, channel count, counter width, version.
    function automatic logic [31:0] id_word(input int num_ch, input int cnt_w);
        logic [7:0] n;
        logic [7:0] w;
        n = 8'(num_ch);
        w = 8'(cnt_w);
        return {ID_MAGIC, n, w, ID_VERSION};
    endfunction

endpackage

// File: rtl/avalon_pwm_multi_channel.sv
// One PWM channel: period counter, double-buffered period/duty shadows,
// duty compare and registered output.
module pwm_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,      // GEN & EN for this channel
    input  logic             tick,        // shared prescaler tick
    input  logic             sync,        // phase-align request
    input  logic             inv,         // output polarity
    input  logic [CNT_W-1:0] period_in,   // live PERIOD incl. same-cycle write
    input  logic [CNT_W-1:0] duty_in,     // live DUTY incl. same-cycle write
    output logic             pwm_out,
    output logic             period_end   // one-cycle pulse on wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_act_q, per_act_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic             pwm_q, pwm_d;

    // Counter advance, wrap detection, shadow reload and output compare.
    always_comb begin
        cnt_d      = cnt_q;
        per_act_d  = per_act_q;
        duty_act_d = duty_act_q;
        period_end = 1'b0;
        if (!active || sync) begin
            // Idle or re-phasing: park the counter and track the live values.
            cnt_d      = '0;
            per_act_d  = period_in;
            duty_act_d = duty_in;
        end else if (tick) begin
            // Wrap compares against the shadow so a smaller PERIOD written
            // mid-period cannot strand the counter above it.
            if (cnt_q == per_act_q) begin
                cnt_d      = '0;
                per_act_d  = period_in;
                duty_act_d = duty_in;
                period_end = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        pwm_d = active ? ((cnt_q < duty_act_q) ^ inv) : inv;
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            per_act_q  <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/avalon_pwm_multi.sv
// Avalon-MM slave with NUM_CH PWM channels sharing one prescaler.
// Holds the register file, prescaler and bus decode; channels live in
// pwm_channel. Optional macro AVALON_PWM_IRQ_EN adds IRQ_MASK and irq.
module avalon_pwm_multi
    import avalon_pwm_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 16,
    parameter int ADDR_W  = 6
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic [NUM_CH-1:0] pwm_out
`ifdef AVALON_PWM_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic                gen_q, gen_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [PRESC_W-1:0]  presc_cnt_q, presc_cnt_d;
    logic [NUM_CH-1:0]   status_q, status_d;
    logic [31:0]         readdata_q, readdata_d;
    pwm_cfg_t            cfg_q [NUM_CH];
    pwm_cfg_t            cfg_d [NUM_CH];
    logic [CNT_W-1:0]    period_q [NUM_CH];
    logic [CNT_W-1:0]    period_d [NUM_CH];
    logic [CNT_W-1:0]    duty_q [NUM_CH];
    logic [CNT_W-1:0]    duty_d [NUM_CH];
    logic [NUM_CH-1:0]   period_end;
    logic [NUM_CH-1:0]   w1c_mask;
    logic                wr_ctrl;
    logic                sync;
    logic                tick;
    logic                unused_wdata;

`ifdef AVALON_PWM_IRQ_EN
    logic [NUM_CH-1:0]   irq_mask_q, irq_mask_d;
    logic                irq_q, irq_d;
`endif

    assign wr_ctrl      = avs_write && (avs_address == ADDR_W'(REG_CTRL));
    assign sync         = wr_ctrl && avs_writedata[1];
    assign tick         = gen_q && (presc_cnt_q >= presc_q);
    assign w1c_mask     = (avs_write && (avs_address == ADDR_W'(REG_STATUS)))
                          ? avs_writedata[NUM_CH-1:0] : '0;
    assign unused_wdata = ^avs_writedata;

    // Register writes, prescaler count and STATUS set/clear.
    always_comb begin
        gen_d    = gen_q;
        presc_d  = presc_q;
        if (wr_ctrl) gen_d = avs_writedata[0];
        if (avs_write && (avs_address == ADDR_W'(REG_PRESCALE)))
            presc_d = avs_writedata[PRESC_W-1:0];

        // Held at 0 while disabled; >= guards against PRESCALE shrinking
        // below the running count.
        if (!gen_q || sync || tick) presc_cnt_d = '0;
        else                        presc_cnt_d = presc_cnt_q + PRESC_W'(1);

        // A new period-end wins over a simultaneous write-1-to-clear.
        status_d = (status_q & ~w1c_mask) | period_end;

        for (int i = 0; i < NUM_CH; i++) begin
            cfg_d[i]    = cfg_q[i];
            period_d[i] = period_q[i];
            duty_d[i]   = duty_q[i];
            if (avs_write && (avs_address == ADDR_W'(CH_BASE + CH_STRIDE*i + OFS_CFG)))
                cfg_d[i] = pwm_cfg_t'(avs_writedata[1:0]);
            if (avs_write && (avs_address == ADDR_W'(CH_BASE + CH_STRIDE*i + OFS_PERIOD)))
                period_d[i] = avs_writedata[CNT_W-1:0];
            if (avs_write && (avs_address == ADDR_W'(CH_BASE + CH_STRIDE*i + OFS_DUTY)))
                duty_d[i] = avs_writedata[CNT_W-1:0];
        end

`ifdef AVALON_PWM_IRQ_EN
        irq_mask_d = irq_mask_q;
        if (avs_write && (avs_address == ADDR_W'(REG_IRQ_MASK)))
            irq_mask_d = avs_writedata[NUM_CH-1:0];
        irq_d = |(status_q & irq_mask_q);
`endif
    end

    // Read mux; unmapped addresses and idle cycles return 0.
    always_comb begin
        readdata_d = '0;
        if (avs_read) begin
            if (avs_address == ADDR_W'(REG_CTRL))     readdata_d = {31'b0, gen_q};
            if (avs_address == ADDR_W'(REG_PRESCALE)) readdata_d = 32'(presc_q);
            if (avs_address == ADDR_W'(REG_STATUS))   readdata_d = 32'(status_q);
            if (avs_address == ADDR_W'(REG_ID))       readdata_d = id_word(NUM_CH, CNT_W);
`ifdef AVALON_PWM_IRQ_EN
            if (avs_address == ADDR_W'(REG_IRQ_MASK)) readdata_d = 32'(irq_mask_q);
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                if (avs_address == ADDR_W'(CH_BASE + CH_STRIDE*i + OFS_CFG))
                    readdata_d = {30'b0, cfg_q[i]};
                if (avs_address == ADDR_W'(CH_BASE + CH_STRIDE*i + OFS_PERIOD))
                    readdata_d = 32'(period_q[i]);
                if (avs_address == ADDR_W'(CH_BASE + CH_STRIDE*i + OFS_DUTY))
                    readdata_d = 32'(duty_q[i]);
            end
        end
    end

    // Register file and prescaler state.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            gen_q       <= 1'b0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            status_q    <= '0;
            readdata_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cfg_q[i]    <= '0;
                period_q[i] <= '0;
                duty_q[i]   <= '0;
            end
        end else begin
            gen_q       <= gen_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            status_q    <= status_d;
            readdata_q  <= readdata_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cfg_q[i]    <= cfg_d[i];
                period_q[i] <= period_d[i];
                duty_q[i]   <= duty_d[i];
            end
        end
    end

`ifdef AVALON_PWM_IRQ_EN
    // Interrupt mask and registered interrupt output.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    assign avs_readdata = readdata_q;

    // Channels see the post-write PERIOD/DUTY so a write in the wrap cycle
    // lands in the shadow immediately.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            pwm_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk        (clk_clk),
                .rst_n      (reset_reset_n),
                .active     (gen_q && cfg_q[gi].en),
                .tick       (tick),
                .sync       (sync),
                .inv        (cfg_q[gi].inv),
                .period_in  (period_d[gi]),
                .duty_in    (duty_d[gi]),
                .pwm_out    (pwm_out[gi]),
                .period_end (period_end[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_avalon_pwm_multi.sv
// Directed self-checking bench for avalon_pwm_multi (NUM_CH=4, CNT_W=16).
module tb_avalon_pwm_multi;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 16;
    localparam int PRESC_W = 16;
    localparam int ADDR_W  = 6;

    localparam int A_CTRL   = 0;
    localparam int A_PRESC  = 1;
    localparam int A_STATUS = 2;
    localparam int A_ID     = 3;
`ifdef AVALON_PWM_IRQ_EN
    localparam int A_IRQM   = 7;
    localparam int CHB      = 8;
`else
    localparam int CHB      = 4;
`endif

    logic              clk_clk = 1'b0;
    logic              reset_reset_n;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              avs_read;
    logic [31:0]       avs_readdata;
    logic [NUM_CH-1:0] pwm_out;
`ifdef AVALON_PWM_IRQ_EN
    logic              irq;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_clk = ~clk_clk;

    avalon_pwm_multi #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .pwm_out       (pwm_out)
`ifdef AVALON_PWM_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    function automatic int a_cfg(input int ch);    return CHB + 3*ch;     endfunction
    function automatic int a_period(input int ch); return CHB + 3*ch + 1; endfunction
    function automatic int a_duty(input int ch);   return CHB + 3*ch + 2; endfunction

    // Write is captured on the second edge; returns 1 time unit after it.
    task automatic bus_write(input int addr, input logic [31:0] data);
        @(posedge clk_clk); #1;
        avs_address   = ADDR_W'(addr);
        avs_writedata = data;
        avs_write     = 1'b1;
        @(posedge clk_clk); #1;
        avs_write     = 1'b0;
        $display("write addr=%0d data=%h", addr, data);
    endtask

    task automatic bus_read(input int addr, output logic [31:0] data);
        @(posedge clk_clk); #1;
        avs_address = ADDR_W'(addr);
        avs_read    = 1'b1;
        @(posedge clk_clk); #1;
        avs_read    = 1'b0;
        data        = avs_readdata;
        $display("read  addr=%0d data=%h", addr, data);
    endtask

    task automatic sample(input int ch, input int n, output logic [63:0] v);
        v = '0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk_clk); #1;
            v[k] = pwm_out[ch];
        end
        $display("sample ch=%0d n=%0d bits=%h", ch, n, v);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset_reset_n = 1'b0;
        avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1;
        checks++;
        if (pwm_out !== 4'b0000) begin
            errors++; $display("FAIL reset_pwm: got %b expected 0000", pwm_out);
        end
        checks++;
        if (avs_readdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 00000000", avs_readdata);
        end
        reset_reset_n = 1'b1;
        bus_read(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        bus_read(a_period(0), d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_period0: got %h expected 0", d); end
        bus_read(40, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", d); end
    endtask

    task automatic test_id;
        @(posedge clk_clk); #1;
        avs_address = ADDR_W'(A_ID);
        avs_read    = 1'b1;
        @(posedge clk_clk); #1;
        avs_read    = 1'b0;
        $display("read  addr=%0d data=%h", A_ID, avs_readdata);
        checks++;
        if (avs_readdata !== 32'h50041002) begin
            errors++; $display("FAIL id_latency1: got %h expected 50041002", avs_readdata);
        end
    endtask

    task automatic test_basic;
        logic [63:0] v;
        logic [31:0] d;
        bus_write(A_PRESC, 0);
        bus_write(a_period(0), 9);
        bus_write(a_duty(0), 3);
        bus_write(a_cfg(0), 1);
        bus_write(A_CTRL, 1);
        sample(0, 20, v);
        checks++;
        if (v[19:0] !== 20'h01C07) begin
            errors++; $display("FAIL basic_wave: got %h expected 01c07", v[19:0]);
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL basic_status: got %h expected 1", d); end
    endtask

    task automatic test_extremes;
        logic [63:0] v;
        bus_write(a_duty(0), 0);
        bus_write(A_CTRL, 3);
        sample(0, 12, v);
        checks++;
        if (v[11:0] !== 12'h000) begin errors++; $display("FAIL duty0: got %h expected 000", v[11:0]); end
        bus_write(a_duty(0), 20);
        bus_write(A_CTRL, 3);
        sample(0, 12, v);
        checks++;
        if (v[11:0] !== 12'hFFF) begin errors++; $display("FAIL duty_gt_per: got %h expected fff", v[11:0]); end
        bus_write(a_cfg(0), 3);
        sample(0, 12, v);
        checks++;
        if (v[11:0] !== 12'h000) begin errors++; $display("FAIL inv_high: got %h expected 000", v[11:0]); end
        bus_write(a_duty(0), 0);
        bus_write(A_CTRL, 3);
        sample(0, 12, v);
        checks++;
        if (v[11:0] !== 12'hFFF) begin errors++; $display("FAIL inv_duty0: got %h expected fff", v[11:0]); end
        bus_write(a_cfg(0), 2);
        sample(0, 12, v);
        checks++;
        if (v[11:0] !== 12'hFFF) begin errors++; $display("FAIL idle_inv1: got %h expected fff", v[11:0]); end
        bus_write(a_cfg(0), 0);
        sample(0, 12, v);
        checks++;
        if (v[11:0] !== 12'h000) begin errors++; $display("FAIL idle_inv0: got %h expected 000", v[11:0]); end
    endtask

    task automatic test_double_buffer;
        logic [63:0] v;
        bus_write(a_duty(0), 3);
        bus_write(a_cfg(0), 1);
        bus_write(A_CTRL, 3);
        fork
            sample(0, 40, v);
            begin
                bus_write(a_duty(0), 7);          // mid-period
                repeat (16) @(posedge clk_clk);
                bus_write(a_duty(0), 2);          // lands on the wrap edge
            end
        join
        checks++;
        if (v[39:0] !== 40'h00C031FC07) begin
            errors++; $display("FAIL double_buffer: got %h expected 00c031fc07", v[39:0]);
        end
    endtask

    task automatic test_prescaler;
        logic [63:0] v;
        bus_write(A_PRESC, 4);
        bus_write(a_period(1), 1);
        bus_write(a_duty(1), 1);
        bus_write(a_cfg(1), 1);
        bus_write(A_CTRL, 3);
        sample(1, 20, v);
        checks++;
        if (v[19:0] !== 20'h07C1F) begin
            errors++; $display("FAIL prescaler: got %h expected 07c1f", v[19:0]);
        end
    endtask

    task automatic test_sync;
        logic [63:0] v0;
        logic [63:0] v1;
        bus_write(A_PRESC, 0);
        bus_write(a_duty(0), 3);
        bus_write(a_period(1), 4);
        bus_write(a_duty(1), 2);
        repeat (7) @(posedge clk_clk);
        bus_write(A_CTRL, 3);
        fork
            sample(0, 10, v0);
            sample(1, 10, v1);
        join
        checks++;
        if (v0[9:0] !== 10'h007) begin errors++; $display("FAIL sync_ch0: got %h expected 007", v0[9:0]); end
        checks++;
        if (v1[9:0] !== 10'h063) begin errors++; $display("FAIL sync_ch1: got %h expected 063", v1[9:0]); end
    endtask

    task automatic test_status;
        logic [31:0] d;
        bus_write(a_cfg(1), 0);
        bus_write(A_CTRL, 3);                 // wrap edges at S+10, S+20, ...
        bus_write(A_STATUS, 32'hF);           // clears at S+2
        bus_read(A_STATUS, d);
        checks++;
        if (d[0] !== 1'b0) begin errors++; $display("FAIL status_w1c: got %b expected 0", d[0]); end
        repeat (4) @(posedge clk_clk);
        bus_write(A_STATUS, 32'h1);           // clear coincides with set at S+10
        bus_read(A_STATUS, d);
        checks++;
        if (d[0] !== 1'b1) begin errors++; $display("FAIL status_set_wins: got %b expected 1", d[0]); end
    endtask

`ifdef AVALON_PWM_IRQ_EN
    task automatic test_irq;
        bus_write(A_IRQM, 1);
        @(posedge clk_clk); #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_mask_on: got %b expected 1", irq); end
        bus_write(A_CTRL, 3);
        bus_write(A_STATUS, 1);
        @(posedge clk_clk); #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b expected 0", irq); end
        repeat (7) @(posedge clk_clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq); end
        @(posedge clk_clk); #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", irq); end
    endtask
`endif

    task automatic test_async_reset;
        logic [31:0] d;
        bus_write(a_cfg(0), 2);
        repeat (2) @(posedge clk_clk);
        #1;
        checks++;
        if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_idle: got %b expected 1", pwm_out[0]); end
        @(posedge clk_clk); #3;
        reset_reset_n = 1'b0;
        #1;
        checks++;
        if (pwm_out !== 4'b0000) begin errors++; $display("FAIL async_reset_pwm: got %b expected 0000", pwm_out); end
        @(posedge clk_clk); #1;
        reset_reset_n = 1'b1;
        bus_read(a_cfg(0), d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL async_reset_cfg: got %h expected 0", d); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_id();
        test_basic();
        test_extremes();
        test_double_buffer();
        test_prescaler();
        test_sync();
        test_status();
`ifdef AVALON_PWM_IRQ_EN
        test_irq();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
